uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Parametrised UART transmitter with an internal transmit FIFO, a runtime baud divisor, runtime parity and a runtime stop-bit count. Upstream logic pushes bytes over a valid/ready stream. The block serialises them back-to-back onto uart_txd, LSB first, with no idle gap while the FIFO holds data. It is the successor of the single-byte fixed-rate transmitter and sits between the system bus/CPU side and the TXD pad.

Parameters:
PAYLOAD_BITS, 8, data bits per frame (5..9).
FIFO_DEPTH, 16, transmit FIFO entries; power of two, >= 2.
DIV_W, 16, width of the baud divisor input.

Ports:
clk  in  1  system clock.
resetn  in  1  synchronous, active-low reset.
s_valid  in  1  upstream data valid.
s_ready  out  1  FIFO can accept a word; high when fifo_level < FIFO_DEPTH.
s_data  in  PAYLOAD_BITS  word to transmit.
cfg_div  in  DIV_W  clock cycles per UART bit; values 0 and 1 are treated as 2.
cfg_parity  in  2  00 none, 01 even, 10 odd, 11 none.
cfg_two_stop  in  1  0 = one stop bit, 1 = two stop bits.
uart_txd  out  1  registered serial output; idle high.
tx_busy  out  1  high while the FSM is not IDLE.
tx_done  out  1  one-cycle pulse at the end of each frame.
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (resetn low at a clk edge) applies regardless of state:
  - FIFO emptied; fifo_level=0; s_ready=1.
  - FSM to IDLE; uart_txd=1; tx_busy=0; tx_done=0.
  - A frame in progress is abandoned. uart_txd is high from the cycle after the reset edge.
- FIFO:
  - Push on s_valid && s_ready at a clk edge.
  - Pop occurs only in the FSM (see below).
  - Simultaneous push and pop leaves the level unchanged.
  - No push while full (s_ready=0); s_data is ignored then.
  - Pointers wrap modulo FIFO_DEPTH.
  - First-word latency: a word pushed into an empty idle block at edge N is popped at edge N+1. uart_txd goes low after edge N+1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if FIFO is non-empty, pop the head into the shift register and latch cfg_div (clamped), cfg_parity and cfg_two_stop. Go to START.
  - Config inputs are only sampled at pop; changes mid-frame have no effect until the next frame.
  - START: txd=0 for div cycles, then DATA.
  - DATA: PAYLOAD_BITS bits, LSB first, each held div cycles. Then go to PARITY if parity is enabled, otherwise STOP.
  - PARITY: txd = XOR of the data bits (even) or its inverse (odd), held div cycles. Then STOP.
  - STOP: txd=1 for div cycles (1 stop) or 2*div cycles (2 stop).
- End of the final stop bit:
  - tx_done pulses for exactly one cycle.
  - If the FIFO is non-empty, pop the next word in that same cycle and enter START directly; the next start bit follows the last stop bit with zero gap.
  - Otherwise go to IDLE.
- Every bit is exactly div cycles long (a single down-counter reloaded with div-1 per bit).
- Frame length in cycles = div * (1 + PAYLOAD_BITS + P + S), where P is 0/1 for parity and S is 1/2 stop bits.
- uart_txd is always driven from a register; never combinational.
- tx_busy=1 from the cycle after the pop until IDLE is re-entered; it stays high across back-to-back frames.

Test Plan:
- Reset, then cfg_div=4, parity none, 1 stop; push 0xA5 -> uart_txd bits 0,1,0,1,0,0,1,0,1,1, each 4 cycles (40 cycles total); one tx_done pulse; tx_busy falls after stop; fifo_level 1->0.
- cfg_div=3, even parity; push 0x07 -> parity bit 1, frame 33 cycles. Repeat with odd parity -> parity bit 0. Then set cfg_two_stop=1 -> stop-high period of 6 cycles.
- Push 3 words (0x00, 0xFF, 0x55) in consecutive cycles at cfg_div=2 -> three contiguous 20-cycle frames with no idle cycle between them; exactly 3 tx_done pulses; tx_busy high throughout.
- FIFO_DEPTH=4, hold s_valid with 6 words while transmitting -> s_ready drops when fifo_level=4; words are accepted as pops free slots; all 6 words are transmitted in order; none lost or duplicated.
- Change cfg_div 4->8 and parity mid-frame -> current frame unchanged; next frame uses the new settings.
- Assert resetn=0 during the DATA bit 3 of a frame with 2 words queued -> next cycle uart_txd=1, fifo_level=0, tx_busy=0; no tx_done; no further start bit without a new push.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding a UART serialiser with runtime divisor, parity and stop bits.
// Latency: a word pushed into an empty idle block is popped on the next edge; the start bit begins right after.
// Backpressure: s_ready drops while the FIFO holds FIFO_DEPTH words; frames run back-to-back while data is queued.

// uart_tx_fifo_buf: generic synchronous FIFO with a combinational head read.
// Latency: a pushed word is visible at the head on the cycle after the push edge.
// Backpressure: pushes while full and pops while empty are ignored; o_full/o_empty expose the state.
module uart_tx_fifo_buf #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_push_dat,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_head_dat,
    output logic                   o_empty,
    output logic                   o_full,
    output logic [$clog2(DEPTH):0] o_level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_push;
    logic             w_pop;

    assign o_empty    = (r_level == '0);
    assign o_full     = (r_level == (AW+1)'(DEPTH));
    assign o_level    = r_level;
    assign o_head_dat = r_mem[r_rd_ptr];
    assign w_push     = i_push && !o_full;
    assign w_pop      = i_pop && !o_empty;

    // Storage array; contents need no reset because the level gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; level tracks push minus pop.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end
endmodule

module uart_tx_fifo #(
    parameter int PAYLOAD_BITS = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int DIV_W        = 16
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [PAYLOAD_BITS-1:0]     s_data,
    input  logic [DIV_W-1:0]            cfg_div,
    input  logic [1:0]                  cfg_parity,
    input  logic                        cfg_two_stop,
    output logic                        uart_txd,
    output logic                        tx_busy,
    output logic                        tx_done,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int BIT_W = $clog2(PAYLOAD_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                  r_state;
    logic [DIV_W-1:0]        r_cnt;
    logic [DIV_W-1:0]        r_div;
    logic [PAYLOAD_BITS-1:0] r_shift;
    logic [BIT_W-1:0]        r_bit_idx;
    logic                    r_par_en;
    logic                    r_par_bit;
    logic                    r_extra_stop;
    logic                    r_txd;
    logic                    r_busy;
    logic                    r_done;

    logic [PAYLOAD_BITS-1:0] w_fifo_dat;
    logic                    w_fifo_empty;
    logic                    w_fifo_full;
    logic                    w_push;
    logic                    w_pop;
    logic [DIV_W-1:0]        w_div_eff;
    logic                    w_bit_end;
    logic                    w_frame_end;
    logic                    w_par_en_cfg;
    logic                    w_par_bit_cfg;

    assign s_ready  = !w_fifo_full;
    assign w_push   = s_valid && s_ready;
    assign uart_txd = r_txd;
    assign tx_busy  = r_busy;
    assign tx_done  = r_done;

    // Divisors below 2 would leave no room for the down-counter; treat them as 2.
    assign w_div_eff     = (cfg_div < DIV_W'(2)) ? DIV_W'(2) : cfg_div;
    assign w_par_en_cfg  = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
    assign w_par_bit_cfg = (^w_fifo_dat) ^ (cfg_parity == 2'b10);

    // A bit ends when the per-bit down-counter reaches zero; the frame ends on the last stop bit.
    assign w_bit_end   = (r_cnt == '0);
    assign w_frame_end = (r_state == S_STOP) && w_bit_end && !r_extra_stop;

    // Pop either from idle or at the very end of a frame so the next start bit follows with no gap.
    assign w_pop = !w_fifo_empty && ((r_state == S_IDLE) || w_frame_end);

    uart_tx_fifo_buf #(
        .WIDTH (PAYLOAD_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .i_push     (w_push),
        .i_push_dat (s_data),
        .i_pop      (w_pop),
        .o_head_dat (w_fifo_dat),
        .o_empty    (w_fifo_empty),
        .o_full     (w_fifo_full),
        .o_level    (fifo_level)
    );

    // Frame sequencer: owns the serial line, busy flag and done pulse, all registered.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_div        <= DIV_W'(2);
            r_shift      <= '0;
            r_bit_idx    <= '0;
            r_par_en     <= 1'b0;
            r_par_bit    <= 1'b0;
            r_extra_stop <= 1'b0;
            r_txd        <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_pop) begin
                // Configuration is captured here and held for the whole frame.
                r_state      <= S_START;
                r_shift      <= w_fifo_dat;
                r_bit_idx    <= '0;
                r_div        <= w_div_eff;
                r_cnt        <= w_div_eff - DIV_W'(1);
                r_par_en     <= w_par_en_cfg;
                r_par_bit    <= w_par_bit_cfg;
                r_extra_stop <= cfg_two_stop;
                r_txd        <= 1'b0;
                r_busy       <= 1'b1;
                if (w_frame_end) begin
                    r_done <= 1'b1;
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_txd  <= 1'b1;
                        r_busy <= 1'b0;
                    end
                    S_START: begin
                        if (w_bit_end) begin
                            r_state <= S_DATA;
                            r_txd   <= r_shift[0];
                            r_cnt   <= r_div - DIV_W'(1);
                        end else begin
                            r_cnt <= r_cnt - DIV_W'(1);
                        end
                    end
                    S_DATA: begin
                        if (w_bit_end) begin
                            r_cnt <= r_div - DIV_W'(1);
                            if (r_bit_idx == BIT_W'(PAYLOAD_BITS - 1)) begin
                                if (r_par_en) begin
                                    r_state <= S_PARITY;
                                    r_txd   <= r_par_bit;
                                end else begin
                                    r_state <= S_STOP;
                                    r_txd   <= 1'b1;
                                end
                            end else begin
                                r_bit_idx <= r_bit_idx + BIT_W'(1);
                                r_shift   <= r_shift >> 1;
                                r_txd     <= r_shift[1];
                            end
                        end else begin
                            r_cnt <= r_cnt - DIV_W'(1);
                        end
                    end
                    S_PARITY: begin
                        if (w_bit_end) begin
                            r_state <= S_STOP;
                            r_txd   <= 1'b1;
                            r_cnt   <= r_div - DIV_W'(1);
                        end else begin
                            r_cnt <= r_cnt - DIV_W'(1);
                        end
                    end
                    S_STOP: begin
                        if (w_bit_end) begin
                            if (r_extra_stop) begin
                                // Second stop bit: same line level, one more bit period.
                                r_extra_stop <= 1'b0;
                                r_cnt        <= r_div - DIV_W'(1);
                            end else begin
                                r_state <= S_IDLE;
                                r_txd   <= 1'b1;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt - DIV_W'(1);
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_txd   <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: random and directed words checked cycle-by-cycle against a frame-level model.
// The model expands each queued word into its expected bit list and holds every bit for the clamped divisor.
// FIFO depth is reduced to 4 so the full/backpressure path is reachable quickly.
module tb_uart_tx_fifo;
    localparam int PB    = 8;
    localparam int DEPTH = 4;
    localparam int DW    = 16;

    logic          clk = 1'b0;
    logic          resetn;
    logic          s_valid;
    logic          s_ready;
    logic [PB-1:0] s_data;
    logic [DW-1:0] cfg_div;
    logic [1:0]    cfg_parity;
    logic          cfg_two_stop;
    logic          uart_txd;
    logic          tx_busy;
    logic          tx_done;
    logic [2:0]    fifo_level;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [PB-1:0] data;
        logic [DW-1:0] div;
        logic [1:0]    par;
        logic          two;
    } frame_t;

    frame_t        exp_q[$];
    logic [PB-1:0] push_q[$];
    int            max_level;
    int            not_ready_seen;
    int            ready_bad;

    uart_tx_fifo #(
        .PAYLOAD_BITS (PB),
        .FIFO_DEPTH   (DEPTH),
        .DIV_W        (DW)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .cfg_div      (cfg_div),
        .cfg_parity   (cfg_parity),
        .cfg_two_stop (cfg_two_stop),
        .uart_txd     (uart_txd),
        .tx_busy      (tx_busy),
        .tx_done      (tx_done),
        .fifo_level   (fifo_level)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation still running at time %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic void exp_add(input logic [PB-1:0] d, input logic [DW-1:0] dv,
                                    input logic [1:0] p, input logic t);
        frame_t fr;
        fr.data = d;
        fr.div  = dv;
        fr.par  = p;
        fr.two  = t;
        exp_q.push_back(fr);
    endfunction

    function automatic int eff_div(input logic [DW-1:0] d);
        return (d < 2) ? 2 : int'(d);
    endfunction

    // Expected line levels for one frame, one entry per bit period; returns the bit count.
    function automatic int model_seq(input frame_t fr, output logic [11:0] seq);
        int k;
        seq    = '1;
        seq[0] = 1'b0;
        for (int i = 0; i < PB; i++) seq[1 + i] = fr.data[i];
        k = 1 + PB;
        if (fr.par == 2'b01 || fr.par == 2'b10) begin
            seq[k] = (($countones(fr.data) % 2) == 1) ^ (fr.par == 2'b10);
            k++;
        end
        k += fr.two ? 2 : 1;
        return k;
    endfunction

    task automatic push_all();
        int guard;
        guard = 0;
        while (push_q.size() > 0 && guard < 2000) begin
            @(negedge clk);
            guard++;
            s_valid = 1'b1;
            s_data  = push_q[0];
            if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
            if (s_ready === 1'b0) not_ready_seen++;
            if ((s_ready === 1'b0) !== (fifo_level === 3'(DEPTH))) ready_bad++;
            if (s_ready === 1'b1) push_q.delete(0);
        end
        checks++;
        if (push_q.size() != 0) begin
            failures++;
            $display("FAIL push_accept: %0d words still pending after %0d cycles, required 0", push_q.size(), guard);
            push_q.delete();
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    // Checks n frames sent back-to-back; low_now means the current sample is the first start-bit cycle.
    task automatic check_frames(input int n, input bit low_now);
        frame_t      fr;
        logic [11:0] seq;
        int          nb, dv, len, w, bad_c;
        logic        bad_v, exp_v, exp_busy;
        bit          bad, done_bad, busy_bad;
        if (!low_now) begin
            w = 0;
            while (uart_txd !== 1'b0 && w < 400) begin
                @(negedge clk);
                w++;
            end
            checks++;
            if (uart_txd !== 1'b0) begin
                failures++;
                $display("FAIL start_wait: uart_txd=%b after %0d cycles, required 0", uart_txd, w);
                exp_q.delete();
                return;
            end
        end
        for (int f = 0; f < n; f++) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL model_queue: no expected frame for frame %0d, required one", f);
                return;
            end
            fr       = exp_q.pop_front();
            nb       = model_seq(fr, seq);
            dv       = eff_div(fr.div);
            len      = nb * dv;
            bad      = 0;
            done_bad = 0;
            busy_bad = 0;
            bad_c    = 0;
            bad_v    = 1'b0;
            exp_v    = 1'b0;
            for (int c = 0; c < len; c++) begin
                if (c > 0) @(negedge clk);
                if (!bad && uart_txd !== seq[c / dv]) begin
                    bad   = 1;
                    bad_c = c;
                    bad_v = uart_txd;
                    exp_v = seq[c / dv];
                end
                if (c > 0 && tx_done !== 1'b0) done_bad = 1;
                if (tx_busy !== 1'b1) busy_bad = 1;
            end
            @(negedge clk);
            exp_busy = (f != n - 1);
            checks++;
            if (bad) begin
                failures++;
                $display("FAIL frame_bits: data=%h cycle %0d of %0d uart_txd=%b, required %b", fr.data, bad_c, len, bad_v, exp_v);
            end
            checks++;
            if (done_bad || tx_done !== 1'b1) begin
                failures++;
                $display("FAIL tx_done: data=%h spurious=%0d end_pulse=%b, required spurious=0 end_pulse=1", fr.data, done_bad, tx_done);
            end
            checks++;
            if (busy_bad) begin
                failures++;
                $display("FAIL tx_busy_frame: data=%h busy dropped inside frame, required 1 throughout", fr.data);
            end
            checks++;
            if (tx_busy !== exp_busy) begin
                failures++;
                $display("FAIL tx_busy_end: data=%h tx_busy=%b after frame, required %b", fr.data, tx_busy, exp_busy);
            end
            if (f == n - 1) begin
                checks++;
                if (uart_txd !== 1'b1) begin
                    failures++;
                    $display("FAIL idle_line: uart_txd=%b after last frame, required 1", uart_txd);
                end
            end
        end
    endtask

    task automatic test_reset();
        resetn       = 1'b0;
        s_valid      = 1'b0;
        s_data       = '0;
        cfg_div      = 16'd4;
        cfg_parity   = 2'b00;
        cfg_two_stop = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (uart_txd !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: txd=%b busy=%b done=%b, required 1 0 0", uart_txd, tx_busy, tx_done);
        end
        checks++;
        if (fifo_level !== 3'd0 || s_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_fifo: level=%0d s_ready=%b, required 0 1", fifo_level, s_ready);
        end
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        cfg_div = 16'd4; cfg_parity = 2'b00; cfg_two_stop = 1'b0;
        exp_add(8'hA5, 16'd4, 2'b00, 1'b0);
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = 8'hA5;
        @(negedge clk);
        s_valid = 1'b0;
        checks++;
        if (fifo_level !== 3'd1 || uart_txd !== 1'b1 || tx_busy !== 1'b0) begin
            failures++;
            $display("FAIL first_push: level=%0d txd=%b busy=%b, required 1 1 0", fifo_level, uart_txd, tx_busy);
        end
        @(negedge clk);
        checks++;
        if (fifo_level !== 3'd0 || uart_txd !== 1'b0 || tx_busy !== 1'b1) begin
            failures++;
            $display("FAIL first_pop: level=%0d txd=%b busy=%b, required 0 0 1", fifo_level, uart_txd, tx_busy);
        end
        check_frames(1, 1'b1);
    endtask

    task automatic send_one(input logic [PB-1:0] d);
        exp_add(d, cfg_div, cfg_parity, cfg_two_stop);
        push_q.push_back(d);
        fork
            push_all();
            check_frames(1, 1'b0);
        join
    endtask

    task automatic test_parity();
        cfg_div = 16'd3; cfg_parity = 2'b01; cfg_two_stop = 1'b0;
        send_one(8'h07);
        cfg_parity = 2'b10;
        send_one(8'h07);
        cfg_two_stop = 1'b1;
        send_one(8'h07);
        cfg_two_stop = 1'b0;
    endtask

    task automatic test_back_to_back();
        cfg_div = 16'd2; cfg_parity = 2'b00; cfg_two_stop = 1'b0;
        exp_add(8'h00, 16'd2, 2'b00, 1'b0);
        exp_add(8'hFF, 16'd2, 2'b00, 1'b0);
        exp_add(8'h55, 16'd2, 2'b00, 1'b0);
        push_q.push_back(8'h00);
        push_q.push_back(8'hFF);
        push_q.push_back(8'h55);
        fork
            push_all();
            check_frames(3, 1'b0);
        join
    endtask

    task automatic test_fifo_full();
        logic [PB-1:0] d;
        cfg_div = 16'd2; cfg_parity = 2'b00; cfg_two_stop = 1'b0;
        max_level = 0; not_ready_seen = 0; ready_bad = 0;
        for (int i = 0; i < 6; i++) begin
            d = PB'($urandom);
            push_q.push_back(d);
            exp_add(d, 16'd2, 2'b00, 1'b0);
        end
        fork
            push_all();
            check_frames(6, 1'b0);
        join
        checks++;
        if (max_level != DEPTH) begin
            failures++;
            $display("FAIL fifo_peak: max level %0d, required %0d", max_level, DEPTH);
        end
        checks++;
        if (not_ready_seen == 0) begin
            failures++;
            $display("FAIL ready_drop: s_ready never low, required at least one cycle low");
        end
        checks++;
        if (ready_bad != 0) begin
            failures++;
            $display("FAIL ready_vs_level: %0d cycles where s_ready low did not match level==%0d, required 0", ready_bad, DEPTH);
        end
    endtask

    task automatic test_cfg_change();
        cfg_div = 16'd4; cfg_parity = 2'b00; cfg_two_stop = 1'b0;
        exp_add(8'h3C, 16'd4, 2'b00, 1'b0);
        exp_add(8'hC1, 16'd8, 2'b01, 1'b0);
        push_q.push_back(8'h3C);
        push_q.push_back(8'hC1);
        fork
            push_all();
            check_frames(2, 1'b0);
            begin
                repeat (12) @(negedge clk);
                cfg_div    = 16'd8;
                cfg_parity = 2'b01;
            end
        join
        cfg_div = 16'd4; cfg_parity = 2'b00;
    endtask

    task automatic test_reset_midframe();
        int w;
        bit idle_bad;
        cfg_div = 16'd4; cfg_parity = 2'b00; cfg_two_stop = 1'b0;
        push_q.push_back(8'h96);
        push_q.push_back(8'h11);
        push_q.push_back(8'h22);
        w = 0;
        fork
            push_all();
            begin
                while (uart_txd !== 1'b0 && w < 400) begin
                    @(negedge clk);
                    w++;
                end
                repeat (17) @(negedge clk);
            end
        join
        checks++;
        if (fifo_level !== 3'd2 || uart_txd !== 1'b0) begin
            failures++;
            $display("FAIL pre_reset: level=%0d txd=%b during data bit 3 of 0x96, required 2 0", fifo_level, uart_txd);
        end
        resetn = 1'b0;
        @(negedge clk);
        checks++;
        if (uart_txd !== 1'b1 || fifo_level !== 3'd0 || tx_busy !== 1'b0 || tx_done !== 1'b0 || s_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset: txd=%b level=%0d busy=%b done=%b ready=%b, required 1 0 0 0 1",
                     uart_txd, fifo_level, tx_busy, tx_done, s_ready);
        end
        resetn   = 1'b1;
        idle_bad = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (uart_txd !== 1'b1 || tx_done !== 1'b0 || tx_busy !== 1'b0 || fifo_level !== 3'd0) idle_bad = 1;
        end
        checks++;
        if (idle_bad) begin
            failures++;
            $display("FAIL post_reset_idle: activity seen after reset with no push, required idle line");
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            cfg_div      = DW'($urandom_range(0, 5));
            cfg_parity   = 2'($urandom_range(0, 3));
            cfg_two_stop = 1'($urandom_range(0, 1));
            send_one(PB'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_parity();
        test_back_to_back();
        test_fifo_full();
        test_cfg_change();
        test_reset_midframe();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
